// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: accepts one command at a time from a
// valid/ready stream, runs a single Wishbone cycle with bounded retry and an
// optional watchdog, and returns one response record per command.
module wb_cmd_master #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int RETRY_LIMIT  = 3,
    parameter int TIMEOUT      = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_data,
    input  logic [SELECT_WIDTH-1:0] cmd_sel,
    input  logic                    cmd_we,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [1:0]              rsp_status,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    output logic                    wbm_we_o,
    output logic [SELECT_WIDTH-1:0] wbm_sel_o,
    output logic                    wbm_stb_o,
    input  logic                    wbm_ack_i,
    input  logic                    wbm_err_i,
    input  logic                    wbm_rty_i,
    output logic                    wbm_cyc_o,
    output logic                    busy
);

    // Counter widths; a disabled feature still gets a 1-bit counter.
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;

    localparam logic [1:0] ST_ACK     = 2'd0;
    localparam logic [1:0] ST_ERR     = 2'd1;
    localparam logic [1:0] ST_RTY     = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CYCLE,
        S_BACKOFF,
        S_RESP
    } state_t;

    state_t                  r_state;
    logic [RW-1:0]           r_retry;
    logic [TW-1:0]           r_timer;
    logic                    r_we;          // command direction, kept while we_o is forced low
    logic                    r_cmd_ready;
    logic [DATA_WIDTH-1:0]   r_rsp_data;
    logic [1:0]              r_rsp_status;
    logic                    r_rsp_valid;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_dat_o;
    logic                    r_we_o;
    logic [SELECT_WIDTH-1:0] r_sel;
    logic                    r_stb;
    logic                    r_cyc;
    logic                    r_busy;

    logic w_timeout;
    logic w_retry_left;

    // Watchdog fires on the last permitted cycle of cyc when nothing terminated it.
    assign w_timeout    = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT - 1));
    assign w_retry_left = (r_retry < RW'(RETRY_LIMIT));

    // Single FSM: all outputs are registered and updated together with the state.
    // NOTE: asynchronous reset clears every output register so cyc/stb drop the
    // moment rst rises, not at the next edge; all state uses non-blocking '<='
    // so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_retry      <= '0;
            r_timer      <= '0;
            r_we         <= 1'b0;
            r_cmd_ready  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
            r_rsp_valid  <= 1'b0;
            r_adr        <= '0;
            r_dat_o      <= '0;
            r_we_o       <= 1'b0;
            r_sel        <= '0;
            r_stb        <= 1'b0;
            r_cyc        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_adr       <= cmd_addr;
                        r_sel       <= cmd_sel;
                        r_we        <= cmd_we;
                        r_we_o      <= cmd_we;
                        r_dat_o     <= cmd_we ? cmd_data : '0;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_retry     <= '0;
                        r_timer     <= '0;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= S_CYCLE;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_CYCLE: begin
                    if (wbm_err_i || wbm_ack_i || wbm_rty_i || w_timeout) begin
                        r_cyc  <= 1'b0;
                        r_stb  <= 1'b0;
                        r_we_o <= 1'b0;
                    end
                    if (wbm_err_i) begin
                        r_rsp_status <= ST_ERR;
                        r_rsp_data   <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (wbm_ack_i) begin
                        r_rsp_status <= ST_ACK;
                        r_rsp_data   <= r_we ? '0 : wbm_dat_i;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else if (wbm_rty_i) begin
                        if (w_retry_left) begin
                            r_retry <= r_retry + RW'(1);
                            r_state <= S_BACKOFF;
                        end else begin
                            r_rsp_status <= ST_RTY;
                            r_rsp_data   <= '0;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end else if (w_timeout) begin
                        r_rsp_status <= ST_TIMEOUT;
                        r_rsp_data   <= '0;
                        r_rsp_valid  <= 1'b1;
                        r_state      <= S_RESP;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_BACKOFF: begin
                    r_cyc   <= 1'b1;
                    r_stb   <= 1'b1;
                    r_we_o  <= r_we;
                    r_timer <= '0;
                    r_state <= S_CYCLE;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;
    assign rsp_valid  = r_rsp_valid;
    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_dat_o;
    assign wbm_we_o   = r_we_o;
    assign wbm_sel_o  = r_sel;
    assign wbm_stb_o  = r_stb;
    assign wbm_cyc_o  = r_cyc;
    assign busy       = r_busy;

endmodule
